// File: rtl/fifo_arbiter_if.sv
// Bus bundle between the arbiter, its producers, the repeat-count queue
// and the downstream consumer. The master side is the arbiter itself.
interface fifo_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;

    logic                          fifo_enqueue;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_dequeue;
    logic [DATA_WIDTH-1:0]         fifo_data_out;
    logic                          fifo_full;
    logic                          fifo_empty;

    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_ready;
    logic                          out_last;

    modport master (
        input  req, req_data, fifo_data_out, fifo_full, fifo_empty, out_ready,
        output grant, fifo_enqueue, fifo_data_in, fifo_dequeue,
               out_valid, out_data, out_last
    );

    modport slave (
        output req, req_data, fifo_data_out, fifo_full, fifo_empty, out_ready,
        input  grant, fifo_enqueue, fifo_data_in, fifo_dequeue,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter feeding a repeat-count queue, with a consumer port
// that replays each head entry count-field times and a flush mode that
// drains the queue without presenting data.
//
//  state | meaning
//  RUN   | arbitrate producers into the queue, serve the consumer
//  FLUSH | block producers, dequeue every repeat until the queue is empty
module fifo_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    fifo_arbiter_if.master       bus,
    output logic                 flushing,
    output logic                 drop_err,
    output logic [15:0]          grant_count,
    output logic [7:0]           drop_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        grant_count_q, grant_count_d;
    logic [7:0]         drop_count_q, drop_count_d;

    logic               win_found;
    int                 win_i;
    logic [DATA_WIDTH-1:0] win_data;
    logic               win_cnt_zero;
    logic [NUM_REQ-1:0] grant_c;
    logic               enq_c;
    logic [DATA_WIDTH-1:0] din_c;
    logic               drop_c;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_i     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_i     = idx;
            end
        end
        win_data     = bus.req_data[win_i*DATA_WIDTH +: DATA_WIDTH];
        win_cnt_zero = (win_data[CNT_WIDTH-1:0] == '0);
    end

    // Zero-latency grant: a zero-count entry is acknowledged and dropped even
    // when the queue is full, since it never needs a queue slot.
    always_comb begin
        grant_c = '0;
        enq_c   = 1'b0;
        din_c   = '0;
        drop_c  = 1'b0;
        if (state_q == RUN && win_found) begin
            if (win_cnt_zero) begin
                grant_c = NUM_REQ'(1) << win_i;
                drop_c  = 1'b1;
            end else if (!bus.fifo_full) begin
                grant_c = NUM_REQ'(1) << win_i;
                enq_c   = 1'b1;
                din_c   = win_data;
            end
        end
    end

    // Consumer side: data is only presented in RUN; FLUSH discards silently.
    always_comb begin
        bus.out_data = bus.fifo_data_out;
        if (state_q == RUN) begin
            bus.out_valid    = !bus.fifo_empty;
            bus.out_last     = !bus.fifo_empty &&
                               (bus.fifo_data_out[CNT_WIDTH-1:0] == CNT_WIDTH'(1));
            bus.fifo_dequeue = !bus.fifo_empty && bus.out_ready;
        end else begin
            bus.out_valid    = 1'b0;
            bus.out_last     = 1'b0;
            bus.fifo_dequeue = !bus.fifo_empty;
        end
    end

    assign bus.grant        = grant_c;
    assign bus.fifo_enqueue = enq_c;
    assign bus.fifo_data_in = din_c;
    assign drop_err         = drop_c;
    assign flushing         = (state_q == FLUSH);
    assign grant_count      = grant_count_q;
    assign drop_count       = drop_count_q;

    // Next state, pointer advance and saturating statistics.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_count_d = grant_count_q;
        drop_count_d  = drop_count_q;

        case (state_q)
            RUN:     if (flush) state_d = FLUSH;
            // A flush arriving on the emptying edge restarts the drain.
            FLUSH:   if (bus.fifo_empty && !flush) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (grant_c != '0)
            rr_ptr_d = PTR_W'((win_i + 1) % NUM_REQ);
        if (enq_c && grant_count_q != 16'hFFFF)
            grant_count_d = grant_count_q + 16'd1;
        if (drop_c && drop_count_q != 8'hFF)
            drop_count_d = drop_count_q + 8'd1;
    end

    // State registers; reset abandons any drain in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            rr_ptr_q      <= '0;
            grant_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_count_q <= grant_count_d;
            drop_count_q  <= drop_count_d;
        end
    end
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: a vector table for the arbitration and
// consumer paths, then hand-written flush and reset sequences.
module tb_fifo_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        flushing;
    logic        drop_err;
    logic [15:0] gc;
    logic [7:0]  dc;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus.master),
        .flushing    (flushing),
        .drop_err    (drop_err),
        .grant_count (gc),
        .drop_count  (dc)
    );

    typedef struct {
        logic [3:0]   req;
        logic [127:0] rdata;
        logic         full;
        logic         empty;
        logic [31:0]  dout;
        logic         ready;
        logic [3:0]   e_grant;
        logic         e_enq;
        logic [31:0]  e_din;
        logic         e_drop;
        logic         e_ov;
        logic         e_last;
        logic         e_deq;
        logic [15:0]  e_gc;
        logic [7:0]   e_dc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] req, input logic [127:0] rdata,
                       input logic full, input logic empty,
                       input logic [31:0] dout, input logic ready,
                       input logic [3:0] e_grant, input logic e_enq,
                       input logic [31:0] e_din, input logic e_drop,
                       input logic e_ov, input logic e_last, input logic e_deq,
                       input logic [15:0] e_gc, input logic [7:0] e_dc);
        vec_t v;
        v.req = req; v.rdata = rdata; v.full = full; v.empty = empty;
        v.dout = dout; v.ready = ready; v.e_grant = e_grant; v.e_enq = e_enq;
        v.e_din = e_din; v.e_drop = e_drop; v.e_ov = e_ov; v.e_last = e_last;
        v.e_deq = e_deq; v.e_gc = e_gc; v.e_dc = e_dc;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] D0 = 32'hA000_0003;
    localparam logic [31:0] D1 = 32'hA010_0003;
    localparam logic [31:0] D2 = 32'hA020_0003;
    localparam logic [31:0] D3 = 32'hA030_0003;
    localparam logic [31:0] DZ = 32'hDEAD_0000;
    localparam logic [31:0] DC1 = 32'h1234_0001;

    initial begin
        logic [127:0] rd_all;
        rd_all = {D3, D2, D1, D0};

        //   req     data                  full empty dout          rdy  grant   enq din   drop ov last deq gc     dc
        add(4'h0, rd_all,               0, 1, 32'h0,         0, 4'b0000, 0, 32'h0, 0, 0, 0, 0, 16'd0, 8'd0);
        add(4'hF, rd_all,               0, 1, 32'h0,         0, 4'b0001, 1, D0,    0, 0, 0, 0, 16'd0, 8'd0);
        add(4'hF, rd_all,               0, 1, 32'h0,         0, 4'b0010, 1, D1,    0, 0, 0, 0, 16'd1, 8'd0);
        add(4'hF, rd_all,               0, 1, 32'h0,         0, 4'b0100, 1, D2,    0, 0, 0, 0, 16'd2, 8'd0);
        add(4'hF, rd_all,               0, 1, 32'h0,         0, 4'b1000, 1, D3,    0, 0, 0, 0, 16'd3, 8'd0);
        add(4'hF, rd_all,               0, 1, 32'h0,         0, 4'b0001, 1, D0,    0, 0, 0, 0, 16'd4, 8'd0);
        add(4'h5, rd_all,               0, 1, 32'h0,         0, 4'b0100, 1, D2,    0, 0, 0, 0, 16'd5, 8'd0);
        add(4'h3, rd_all,               0, 1, 32'h0,         0, 4'b0001, 1, D0,    0, 0, 0, 0, 16'd6, 8'd0);
        add(4'h4, {D3, DZ, D1, D0},     1, 1, 32'h0,         0, 4'b0100, 0, 32'h0, 1, 0, 0, 0, 16'd7, 8'd0);
        add(4'h1, {D3, D2, D1, DC1},    1, 1, 32'h0,         0, 4'b0000, 0, 32'h0, 0, 0, 0, 0, 16'd7, 8'd1);
        add(4'h1, {D3, D2, D1, DC1},    0, 1, 32'h0,         0, 4'b0001, 1, DC1,   0, 0, 0, 0, 16'd7, 8'd1);
        add(4'h0, rd_all,               0, 0, 32'h5555_0002, 1, 4'b0000, 0, 32'h0, 0, 1, 0, 1, 16'd8, 8'd1);
        add(4'h0, rd_all,               0, 0, 32'h5555_0001, 1, 4'b0000, 0, 32'h0, 0, 1, 1, 1, 16'd8, 8'd1);
        add(4'h0, rd_all,               0, 1, 32'h5555_0001, 1, 4'b0000, 0, 32'h0, 0, 0, 0, 0, 16'd8, 8'd1);
        add(4'h0, rd_all,               0, 0, 32'h6666_0001, 0, 4'b0000, 0, 32'h0, 0, 1, 1, 0, 16'd8, 8'd1);
        add(4'h2, rd_all,               0, 0, 32'h7777_0005, 1, 4'b0010, 1, D1,    0, 1, 0, 1, 16'd8, 8'd1);

        // Reset state
        bus.req = '0; bus.req_data = rd_all; bus.fifo_full = 1'b0;
        bus.fifo_empty = 1'b1; bus.fifo_data_out = '0; bus.out_ready = 1'b0;
        #1;
        chk("rst_flushing", 32'(flushing), 32'd0);
        chk("rst_gc", 32'(gc), 32'd0);
        chk("rst_dc", 32'(dc), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();

        foreach (vq[i]) begin
            bus.req = vq[i].req; bus.req_data = vq[i].rdata;
            bus.fifo_full = vq[i].full; bus.fifo_empty = vq[i].empty;
            bus.fifo_data_out = vq[i].dout; bus.out_ready = vq[i].ready;
            #2;
            chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vq[i].e_grant));
            chk($sformatf("v%0d_enq", i), 32'(bus.fifo_enqueue), 32'(vq[i].e_enq));
            chk($sformatf("v%0d_din", i), bus.fifo_data_in, vq[i].e_din);
            chk($sformatf("v%0d_drop", i), 32'(drop_err), 32'(vq[i].e_drop));
            chk($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'(vq[i].e_ov));
            chk($sformatf("v%0d_last", i), 32'(bus.out_last), 32'(vq[i].e_last));
            chk($sformatf("v%0d_deq", i), 32'(bus.fifo_dequeue), 32'(vq[i].e_deq));
            chk($sformatf("v%0d_gc", i), 32'(gc), 32'(vq[i].e_gc));
            chk($sformatf("v%0d_dc", i), 32'(dc), 32'(vq[i].e_dc));
            chk($sformatf("v%0d_flushing", i), 32'(flushing), 32'd0);
            if (vq[i].e_ov) chk($sformatf("v%0d_odata", i), bus.out_data, vq[i].dout);
            tick();
        end
        chk("tbl_gc_final", 32'(gc), 32'd9);
        chk("tbl_dc_final", 32'(dc), 32'd1);

        // Flush drains 2+3 repeats; rr_ptr is 2 here.
        bus.req = '0; bus.fifo_empty = 1'b0; bus.fifo_data_out = 32'h8888_0002;
        bus.out_ready = 1'b1; flush = 1'b1;
        #2;
        chk("fl_pre_flushing", 32'(flushing), 32'd0);
        tick();
        flush = 1'b0; bus.req = 4'hF; bus.req_data = rd_all;
        for (int c = 0; c < 5; c++) begin
            bus.fifo_data_out = (c < 2) ? 32'h8888_0002 - 32'(c) : 32'h9999_0003 - 32'(c - 2);
            #1;
            chk($sformatf("fl%0d_flushing", c), 32'(flushing), 32'd1);
            chk($sformatf("fl%0d_deq", c), 32'(bus.fifo_dequeue), 32'd1);
            chk($sformatf("fl%0d_ov", c), 32'(bus.out_valid), 32'd0);
            chk($sformatf("fl%0d_last", c), 32'(bus.out_last), 32'd0);
            chk($sformatf("fl%0d_grant", c), 32'(bus.grant), 32'd0);
            chk($sformatf("fl%0d_enq", c), 32'(bus.fifo_enqueue), 32'd0);
            chk($sformatf("fl%0d_drop", c), 32'(drop_err), 32'd0);
            tick();
        end
        bus.fifo_empty = 1'b1;
        #1;
        chk("fl_empty_flushing", 32'(flushing), 32'd1);
        chk("fl_empty_deq", 32'(bus.fifo_dequeue), 32'd0);
        tick();
        chk("fl_done_flushing", 32'(flushing), 32'd0);
        chk("fl_done_grant", 32'(bus.grant), 32'b0100);
        chk("fl_done_gc", 32'(gc), 32'd9);
        bus.req = '0;

        // Flush held on the emptying edge keeps FLUSH.
        flush = 1'b1;
        tick();
        chk("hold_enter", 32'(flushing), 32'd1);
        tick();
        chk("hold_stay", 32'(flushing), 32'd1);
        flush = 1'b0;
        tick();
        chk("hold_exit", 32'(flushing), 32'd0);

        // Move rr_ptr off zero, then reset in the middle of a drain.
        bus.req = 4'b0001;
        tick();
        chk("pre_rst_gc", 32'(gc), 32'd10);
        bus.req = '0; bus.out_ready = 1'b0; bus.fifo_empty = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pre_rst_flushing", 32'(flushing), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_flushing", 32'(flushing), 32'd0);
        chk("mid_rst_gc", 32'(gc), 32'd0);
        chk("mid_rst_dc", 32'(dc), 32'd0);
        chk("mid_rst_deq", 32'(bus.fifo_dequeue), 32'd0);
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd1);
        bus.req = 4'hF;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each queue entry.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of producers.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, repeat-count field width, located at entry bits [CNT_WIDTH-1:0].
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-producer request, held until granted.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  producer i entry at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 grant  output  NUM_REQ  one-hot acknowledge; producer i may drop req after an edge with grant[i]=1.
REQ-009 fifo_enqueue  output  1  enqueue strobe to queue.
REQ-010 fifo_data_in  output  DATA_WIDTH  entry to queue.
REQ-011 fifo_dequeue  output  1  dequeue strobe to queue (one repeat-count decrement per cycle).
REQ-012 fifo_data_out  input  DATA_WIDTH  queue head entry.
REQ-013 fifo_full, fifo_empty  input  1 each  queue status.
REQ-014 flush  input  1  single-cycle flush request.
REQ-015 out_valid, out_data, out_ready, out_last  output 1 / output DATA_WIDTH / input 1 / output 1  consumer handshake.
REQ-016 flushing  output  1  high while in FLUSH state.
REQ-017 drop_err  output  1  single-cycle pulse on a zero-count drop.
REQ-018 grant_count  output  16  accepted-enqueue counter; drop_count  output  8  dropped-entry counter.

Function
REQ-019 FSM SHALL have states RUN and FLUSH; reset state RUN.
REQ-020 RUN->FLUSH at an edge with flush=1; flush in FLUSH SHALL be ignored.
REQ-021 FLUSH->RUN at the first edge sampling fifo_empty=1; flush=1 on that edge SHALL keep state FLUSH.
REQ-022 Arbitration SHALL be round-robin from pointer rr_ptr (reset 0): winner = first i with req[i]=1 searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-023 Winner, grant, fifo_enqueue, fifo_data_in SHALL be combinational from current req, req_data, rr_ptr, state, fifo_full (zero-latency grant).
REQ-024 In RUN with a winner whose count field is nonzero and fifo_full=0: grant[winner]=1, fifo_enqueue=1, fifo_data_in=req_data of winner.
REQ-025 In RUN with a winner whose count field is zero: grant[winner]=1, fifo_enqueue=0, drop_err=1, regardless of fifo_full.
REQ-026 Nonzero-count winner with fifo_full=1: grant=0, fifo_enqueue=0, rr_ptr unchanged.
REQ-027 On any edge with grant nonzero, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-028 In FLUSH: grant=0, fifo_enqueue=0, drop_err=0.
REQ-029 In RUN: out_valid = !fifo_empty; out_data = fifo_data_out; fifo_dequeue = out_valid && out_ready.
REQ-030 out_last SHALL be out_valid && out_data count field == 1.
REQ-031 In FLUSH: out_valid=0, out_last=0, fifo_dequeue = !fifo_empty (drains every repeat of every entry).
REQ-032 fifo_data_in SHALL be 0 when fifo_enqueue=0.
REQ-033 grant_count SHALL increment at each edge with fifo_enqueue=1, saturating at 16'hFFFF.
REQ-034 drop_count SHALL increment at each edge with drop_err=1, saturating at 8'hFF.
REQ-035 Simultaneous enqueue and dequeue in one cycle SHALL be permitted; no interlock between them.

Reset
REQ-036 reset=0 SHALL immediately force state RUN, rr_ptr=0, grant_count=0, drop_count=0, independent of clk.
REQ-037 During reset, outputs SHALL follow REQ-023..031 from reset state; any FLUSH in progress SHALL be abandoned without draining.

Verification
REQ-038 req=4'b1111, all counts 3, queue empty, no full -> grants 0,1,2,3,0 on successive edges; grant_count=5 after 5 edges.
REQ-039 req[2]=1, data count 0 -> grant[2]=1, fifo_enqueue=0, drop_err=1 one cycle, drop_count=1, queue unchanged.
REQ-040 Head entry count 2, out_ready=1 -> out_valid two cycles, out_last=0 then 1, then fifo_empty=1 and out_valid=0.
REQ-041 fifo_full=1, req[0]=1 (count 1) -> grant=0, rr_ptr held; fifo_full falls -> grant[0]=1 same cycle.
REQ-042 Queue holds entries with counts 2 and 3, pulse flush -> flushing=1, fifo_dequeue=1 for 5 cycles, out_valid=0, grants blocked; RUN on edge after empty.
REQ-043 reset=0 asserted mid-FLUSH, between clock edges -> flushing=0 immediately, counters 0, rr_ptr 0.
